// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit sides: byte width, default
// buffer sizing, idle timeout, and the timeout FSM state encodings.
package uart_pkg;

    localparam int UART_BYTE_W          = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_ADDR_W       = 4;
    localparam int DEFAULT_TIMEOUT_CLKS = 64;

    localparam logic [1:0] TMO_IDLE  = 2'd0;
    localparam logic [1:0] TMO_ARMED = 2'd1;
    localparam logic [1:0] TMO_FIRED = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO on a register array. Writes are
// pre-qualified by the caller, so a write while full is only issued together with a read.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Head is forced to zero while empty so the output never shows stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Turns the UART receiver's level-style byte-done flag into single FIFO writes,
// streams bytes to the host, tracks overflow and raises a one-shot idle timeout.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_received,
    input  logic [UART_BYTE_W-1:0] rx_data,
    output logic [UART_BYTE_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ADDR_W:0]        fifo_count,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic                   rx_timeout
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    logic                   rx_received_q;
    logic                   push_p0;
    logic [UART_BYTE_W-1:0] data_p0;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;
    logic                   going_empty;
    logic                   full;
    logic                   empty;
    logic [1:0]             tmo_state;
    logic [15:0]            idle_cnt;

    // Stage p0: rising-edge detect of rx_received, byte captured on the same clock.
    // The edge register resets high so a flag held through reset never writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_received_q <= 1'b1;
            push_p0       <= 1'b0;
        end else begin
            rx_received_q <= rx_received;
            push_p0       <= rx_received & ~rx_received_q;
        end
    end

    always_ff @(posedge clock) begin
        data_p0 <= rx_data;
    end

    // Stage p1: FIFO write; a push into a full FIFO is only accepted alongside a pop.
    assign m_valid     = ~empty;
    assign pop         = m_valid & m_ready;
    assign wr_en       = push_p0 & (~full | pop);
    assign drop        = push_p0 & full & ~pop;
    assign going_empty = pop & ~wr_en & (fifo_count == (ADDR_W+1)'(1));

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (UART_BYTE_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (data_p0),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // A new drop outranks a simultaneous clear so no loss goes unreported.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_overflow)
            overflow <= 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_state  <= TMO_IDLE;
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= 1'b0;
            case (tmo_state)
                TMO_IDLE: begin
                    idle_cnt <= '0;
                    if (wr_en)
                        tmo_state <= TMO_ARMED;
                end
                TMO_ARMED: begin
                    if (going_empty) begin
                        tmo_state <= TMO_IDLE;
                        idle_cnt  <= '0;
                    end else if (wr_en) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TMO_LAST) begin
                        rx_timeout <= 1'b1;
                        tmo_state  <= TMO_FIRED;
                        idle_cnt   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                TMO_FIRED: begin
                    idle_cnt <= '0;
                    if (going_empty)
                        tmo_state <= TMO_IDLE;
                    else if (wr_en)
                        tmo_state <= TMO_ARMED;
                end
                default: begin
                    tmo_state <= TMO_IDLE;
                    idle_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
